// File: rtl/blink_monitor.sv
// Receive-side checker for the blink generator: measures high/low phase lengths
// of an asynchronous blink line and flags a line that has stopped toggling.
module blink_monitor #(
    parameter int CNT_W   = 21,
    parameter int TIMEOUT = 300000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blink_in,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level,
    output logic [15:0]      toggle_count
);

    // state    | meaning
    // ST_IDLE  | no phase boundary seen yet, first phase is partial
    // ST_HIGH  | line high, phase length accumulating in run_cnt
    // ST_LOW   | line low, phase length accumulating in run_cnt
    // ST_STUCK | line held one level for TIMEOUT cycles
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;
    localparam logic [1:0] ST_STUCK = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TO1 = CNT_W'(TIMEOUT - 1);

    logic             s1, s2, s3;
    logic [1:0]       state;
    logic [CNT_W-1:0] run_cnt;
    logic             have_high;
    logic             tr, rise, fall, timeout_hit;

    assign tr          = s2 ^ s3;
    assign rise        = tr & s2;
    assign fall        = tr & ~s2;
    // an edge in the same cycle always wins over the timeout
    assign timeout_hit = (state != ST_STUCK) && !tr && (run_cnt == CNT_TO1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            state        <= ST_IDLE;
            run_cnt      <= '0;
            have_high    <= 1'b0;
            high_len     <= '0;
            low_len      <= '0;
            period       <= '0;
            meas_valid   <= 1'b0;
            stuck        <= 1'b0;
            stuck_level  <= 1'b0;
            toggle_count <= '0;
        end else begin
            s1         <= blink_in;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;

            if (tr) begin
                run_cnt      <= CNT_ONE;
                toggle_count <= toggle_count + 16'd1;
            end else if (run_cnt != CNT_MAX) begin
                run_cnt <= run_cnt + CNT_ONE;
            end

            if (timeout_hit) begin
                stuck       <= 1'b1;
                stuck_level <= s2;
                state       <= ST_STUCK;
                have_high   <= 1'b0;
            end else if (tr) begin
                case (state)
                    ST_IDLE: begin
                        state <= rise ? ST_HIGH : ST_LOW;
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            high_len  <= run_cnt;
                            have_high <= 1'b1;
                            state     <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            low_len <= run_cnt;
                            state   <= ST_HIGH;
                            // pair the preceding high phase with the low that just ended
                            if (have_high) begin
                                period     <= {1'b0, high_len} + {1'b0, run_cnt};
                                meas_valid <= 1'b1;
                            end
                        end
                    end
                    ST_STUCK: begin
                        stuck <= 1'b0;
                        state <= rise ? ST_HIGH : ST_LOW;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: square waves, glitches, stuck detection,
// reset mid-phase and toggle counter wrap.
module tb_blink_monitor;

    localparam int CNT_W   = 21;
    localparam int TIMEOUT = 50;

    logic             clk;
    logic             rst_n;
    logic             blink_in;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;
    logic [15:0]      toggle_count;

    int checks = 0;
    int errors = 0;

    int          pulses = 0;
    int          consec = 0;
    logic        prev_mv = 1'b0;
    logic [31:0] p_hi = 0, p_lo = 0, p_per = 0;
    int          snap;

    blink_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blink_in     (blink_in),
        .high_len     (high_len),
        .low_len      (low_len),
        .period       (period),
        .meas_valid   (meas_valid),
        .stuck        (stuck),
        .stuck_level  (stuck_level),
        .toggle_count (toggle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record every meas_valid pulse and any back-to-back pulses
    always @(negedge clk) begin
        if (meas_valid) begin
            pulses = pulses + 1;
            p_hi   = 32'(high_len);
            p_lo   = 32'(low_len);
            p_per  = 32'(period);
            if (prev_mv) consec = consec + 1;
        end
        prev_mv = meas_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic phase(input logic v, input int n);
        blink_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        blink_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_high_len", 32'(high_len), 0);
        check("rst_low_len", 32'(low_len), 0);
        check("rst_period", 32'(period), 0);
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_stuck", 32'(stuck), 0);
        check("rst_toggles", 32'(toggle_count), 0);
        rst_n = 1'b1;

        // square wave high 4 / low 6, five periods starting low
        phase(1'b0, 10);
        snap = pulses;
        for (int i = 0; i < 5; i++) begin
            phase(1'b1, 4);
            phase(1'b0, 6);
        end
        phase(1'b0, 10);
        check("sq_pulses", 32'(pulses - snap), 4);
        check("sq_high", p_hi, 4);
        check("sq_low", p_lo, 6);
        check("sq_period", p_per, 10);
        check("sq_toggles", 32'(toggle_count), 10);
        check("sq_stuck", 32'(stuck), 0);

        // 1-cycle glitches; first rise pairs high 4 with the 16-cycle low
        snap = pulses;
        for (int i = 0; i < 6; i++) begin
            phase(1'b1, 1);
            phase(1'b0, 1);
        end
        phase(1'b0, 5);
        check("gl_pulses", 32'(pulses - snap), 6);
        check("gl_high", p_hi, 1);
        check("gl_low", p_lo, 1);
        check("gl_period", p_per, 2);
        check("gl_consec", 32'(consec), 0);
        check("gl_toggles", 32'(toggle_count), 22);

        // valid period, then hold high until stuck
        phase(1'b1, 4);
        phase(1'b0, 6);
        check("pre_period", p_per, 7);
        snap = pulses;
        phase(1'b1, 51);
        check("stk_not_yet", 32'(stuck), 0);
        phase(1'b1, 1);
        check("stk_rise", 32'(stuck), 1);
        check("stk_level", 32'(stuck_level), 1);
        phase(1'b1, 28);
        check("stk_hold", 32'(stuck), 1);
        check("stk_pulses", 32'(pulses - snap), 1);
        check("stk_period", p_per, 10);
        snap = pulses;
        phase(1'b0, 7);
        check("stk_clear", 32'(stuck), 0);
        check("stk_high_kept", 32'(high_len), 4);
        phase(1'b1, 4);
        phase(1'b0, 5);
        check("stk_no_pulse", 32'(pulses - snap), 0);
        check("stk_low_len", 32'(low_len), 7);
        check("stk_period_kept", 32'(period), 10);
        check("stk_toggles", 32'(toggle_count), 28);

        // reset in the middle of a high phase
        phase(1'b1, 3);
        rst_n = 1'b0;
        phase(1'b1, 2);
        check("mid_rst_high", 32'(high_len), 0);
        check("mid_rst_low", 32'(low_len), 0);
        check("mid_rst_period", 32'(period), 0);
        check("mid_rst_toggles", 32'(toggle_count), 0);
        check("mid_rst_stuck", 32'(stuck), 0);
        rst_n = 1'b1;
        snap = pulses;
        phase(1'b1, 3);
        phase(1'b0, 5);
        phase(1'b1, 3);
        phase(1'b0, 5);
        check("rr_first_pulses", 32'(pulses - snap), 1);
        check("rr_high", p_hi, 3);
        check("rr_low", p_lo, 5);
        check("rr_period", p_per, 8);
        phase(1'b1, 3);
        phase(1'b0, 8);
        check("rr_pulses", 32'(pulses - snap), 2);
        check("rr_toggles", 32'(toggle_count), 6);

        // 65537 transitions wrap the toggle counter to 1
        rst_n = 1'b0;
        phase(1'b0, 2);
        rst_n = 1'b1;
        phase(1'b0, 3);
        snap = pulses;
        for (int i = 0; i < 32768; i++) begin
            phase(1'b1, 1);
            phase(1'b0, 1);
        end
        phase(1'b1, 5);
        check("wrap_toggles", 32'(toggle_count), 1);
        check("wrap_pulses", 32'(pulses - snap), 32768);
        check("wrap_high", p_hi, 1);
        check("wrap_low", p_lo, 1);
        check("wrap_period", p_per, 2);
        check("wrap_consec", 32'(consec), 0);
        check("wrap_stuck", 32'(stuck), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
